// File: rtl/alu_pkg.sv
// Shared constants for the RV32M multiply/divide unit.
package alu_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // funct7 that routes OP instructions to this unit
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Control FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_step.sv
// One combinational iteration over the {hi, lo} accumulator.
// mode_div=0: shift-add multiply step (lo holds the remaining multiplier bits).
// mode_div=1: restoring divide step (hi holds the partial remainder, lo
//             shifts the dividend out and the quotient in).
module alu_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                mode_div,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     opb_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;

  // Compute both candidate updates and select by mode
  always_comb begin
    hi    = acc_i[2*XLEN-1:XLEN];
    lo    = acc_i[XLEN-1:0];
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb_i} : '0);
    trial = {hi, lo[XLEN-1]};
    // The remainder never reaches the divisor, so the low XLEN bits suffice.
    diff  = trial[XLEN-1:0] - opb_i;
    if (mode_div) begin
      if (trial >= {1'b0, opb_i}) acc_o = {diff, lo[XLEN-2:0], 1'b1};
      else                        acc_o = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
//
// state | meaning
// IDLE  | o_Ready=1, waiting for a request
// CALC  | iterating on unsigned magnitudes, BITS_PER_CYCLE steps per cycle
// DONE  | o_Valid=1, result held until the consumer takes it
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [2:0]      i_Funct3_3,
  input  logic [XLEN-1:0] i_Operand1,
  input  logic [XLEN-1:0] i_Operand2,
  input  logic            i_Flush,
  output logic            o_Valid,
  input  logic            i_ResultReady,
  output logic [XLEN-1:0] o_Result
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;    // product / quotient sign
  logic              rneg_q, rneg_d;  // remainder sign (dividend sign)
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg, div_zero, sgn_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, fin_res;
  logic [2*XLEN-1:0] fin, prod_s;
  logic [2*XLEN-1:0] chain [BITS_PER_CYCLE+1];

  assign chain[0] = acc_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    alu_muldiv_step #(.XLEN(XLEN)) u_step (
      .mode_div (f3_q[2]),
      .acc_i    (chain[gi]),
      .opb_i    (opb_q),
      .acc_o    (chain[gi+1])
    );
  end

  // Decode the incoming request: magnitudes, signs and bypass cases
  always_comb begin
    a_neg    = i_Operand1[XLEN-1] && (i_Funct3_3 == F3_MULH || i_Funct3_3 == F3_MULHSU ||
                                      i_Funct3_3 == F3_DIV  || i_Funct3_3 == F3_REM);
    b_neg    = i_Operand2[XLEN-1] && (i_Funct3_3 == F3_MULH || i_Funct3_3 == F3_DIV ||
                                      i_Funct3_3 == F3_REM);
    abs_a    = a_neg ? -i_Operand1 : i_Operand1;
    abs_b    = b_neg ? -i_Operand2 : i_Operand2;
    div_zero = i_Funct3_3[2] && (i_Operand2 == '0);
    sgn_ovf  = (i_Funct3_3 == F3_DIV || i_Funct3_3 == F3_REM) &&
               (i_Operand1 == MIN_NEG) && (i_Operand2 == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = i_Funct3_3[1] ? i_Operand1 : '1;
    else          special_res = i_Funct3_3[1] ? '0 : i_Operand1;
  end

  // Sign-correct and select the result from the last iteration's output
  always_comb begin
    fin    = chain[BITS_PER_CYCLE];
    prod_s = neg_q ? -fin : fin;
    if (!f3_q[2])
      fin_res = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (f3_q[1])
      fin_res = rneg_q ? -fin[2*XLEN-1:XLEN] : fin[2*XLEN-1:XLEN];
    else
      fin_res = neg_q ? -fin[XLEN-1:0] : fin[XLEN-1:0];
  end

  // Next-state logic; flush overrides everything and discards in-flight work
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (i_Valid) begin
          f3_d   = i_Funct3_3;
          acc_d  = {{XLEN{1'b0}}, abs_a};
          opb_d  = abs_b;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (div_zero || sgn_ovf) begin
            result_d = special_res;
            cnt_d    = '0;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(N);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = chain[BITS_PER_CYCLE];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ResultReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_Flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      f3_d     = f3_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign o_Ready  = (state_q == S_IDLE);
  assign o_Valid  = (state_q == S_DONE);
  assign o_Result = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: two instances (1 and 4 bits per cycle) share the same
// input stimulus; each has its own behavioural model lane.
module tb_alu_muldiv;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_Valid = 1'b0;
  logic [2:0]  i_Funct3_3 = 3'd0;
  logic [31:0] i_Operand1 = 32'd0;
  logic [31:0] i_Operand2 = 32'd0;
  logic        i_Flush = 1'b0;
  logic        i_ResultReady = 1'b0;
  logic [1:0]  o_Ready;
  logic [1:0]  o_Valid;
  logic [31:0] o_Result [2];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int lane_n [2] = '{32, 8};

  // model state per lane
  bit          m_busy [2];
  bit          m_valid [2];
  int          m_left [2];
  logic [31:0] m_res [2];
  logic [31:0] m_pend [2];

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_Valid(i_Valid), .o_Ready(o_Ready[0]),
    .i_Funct3_3(i_Funct3_3), .i_Operand1(i_Operand1), .i_Operand2(i_Operand2),
    .i_Flush(i_Flush), .o_Valid(o_Valid[0]), .i_ResultReady(i_ResultReady),
    .o_Result(o_Result[0])
  );

  alu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_Valid(i_Valid), .o_Ready(o_Ready[1]),
    .i_Funct3_3(i_Funct3_3), .i_Operand1(i_Operand1), .i_Operand2(i_Operand2),
    .i_Flush(i_Flush), .o_Valid(o_Valid[1]), .i_ResultReady(i_ResultReady),
    .o_Result(o_Result[1])
  );

  function automatic bit is_special(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (f3 < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF;
  endfunction

  // Reference result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] x, y, p;
    bit as, bs;
    as = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6);
    bs = (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
    x = as ? {{32{a[31]}}, a} : {32'd0, a};
    y = bs ? {{32{b[31]}}, b} : {32'd0, b};
    case (f3)
      3'd0: begin p = x * y; return p[31:0]; end
      3'd1, 3'd2, 3'd3: begin p = x * y; return p[63:32]; end
      3'd4, 3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (f3 == 3'd4 && a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        p = x / y;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        if (f3 == 3'd6 && a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        p = x % y;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN_NEG;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      5: return -32'($urandom_range(1, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: latency-counting request/response per lane
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_res[k] = 32'd0;
      end else if (i_Flush) begin
        m_busy[k] = 1'b0; m_valid[k] = 1'b0;
      end else if (!m_busy[k] && !m_valid[k]) begin
        if (i_Valid) begin
          m_pend[k] = ref_result(i_Funct3_3, i_Operand1, i_Operand2);
          m_left[k] = is_special(i_Funct3_3, i_Operand1, i_Operand2) ? 0 : lane_n[k];
          if (m_left[k] == 0) begin m_valid[k] = 1'b1; m_res[k] = m_pend[k]; end
          else m_busy[k] = 1'b1;
        end
      end else if (m_busy[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_busy[k] = 1'b0; m_valid[k] = 1'b1; m_res[k] = m_pend[k];
        end
      end else if (m_valid[k] && i_ResultReady) begin
        m_valid[k] = 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("lane%0d o_Ready", k), 32'(o_Ready[k]), 32'(!m_busy[k] && !m_valid[k]));
        check($sformatf("lane%0d o_Valid", k), 32'(o_Valid[k]), 32'(m_valid[k]));
        check($sformatf("lane%0d o_Result", k), o_Result[k], m_res[k]);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    i_Valid = 1'b0; i_Flush = 1'b0; i_ResultReady = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!m_busy[0] && !m_valid[0] && !m_busy[1] && !m_valid[1]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    i_ResultReady = 1'b0;
    if (!ok) check("wait_idle timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit sp,
                        input int hold);
    int lat [2];
    bit seen [2];
    wait_idle();
    i_Funct3_3 = f3; i_Operand1 = a; i_Operand2 = b; i_Valid = 1'b1;
    @(negedge clk);
    i_Valid = 1'b0;
    lat = '{0, 0}; seen = '{1'b0, 1'b0};
    for (int cyc = 1; cyc <= 60; cyc++) begin
      for (int k = 0; k < 2; k++)
        if (!seen[k] && o_Valid[k] === 1'b1) begin lat[k] = cyc; seen[k] = 1'b1; end
      if (seen[0] && seen[1]) break;
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s latency lane%0d", nm, k), 32'(lat[k]), 32'(sp ? 1 : lane_n[k] + 1));
      check($sformatf("%s result lane%0d", nm, k), o_Result[k], exp);
    end
    if (hold > 0) begin
      i_Valid = 1'b1; i_Funct3_3 = 3'd5; i_Operand1 = 32'd77; i_Operand2 = 32'd3;
      repeat (hold) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          check($sformatf("%s hold result lane%0d", nm, k), o_Result[k], exp);
          check($sformatf("%s hold ready lane%0d", nm, k), 32'(o_Ready[k]), 32'd0);
        end
      end
    end
    i_ResultReady = 1'b1;
    @(negedge clk);
    i_ResultReady = 1'b0;
    i_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s post-accept ready lane%0d", nm, k), 32'(o_Ready[k]), 32'd1);
      check($sformatf("%s post-accept valid lane%0d", nm, k), 32'(o_Valid[k]), 32'd0);
    end
  endtask

  task automatic abort_test(input string nm, input int calc_cycle, input bit use_rst);
    int pulses = 0;
    wait_idle();
    i_Funct3_3 = 3'd0; i_Operand1 = 32'h1234; i_Operand2 = 32'h5678; i_Valid = 1'b1;
    @(negedge clk);
    i_Valid = 1'b0;
    repeat (calc_cycle - 1) @(negedge clk);
    if (use_rst) rst = 1'b1; else i_Flush = 1'b1;
    i_Valid = 1'b1; i_Funct3_3 = 3'd4; i_Operand1 = 32'd9; i_Operand2 = 32'd0;
    @(negedge clk);
    rst = 1'b0; i_Flush = 1'b0; i_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s ready lane%0d", nm, k), 32'(o_Ready[k]), 32'd1);
      check($sformatf("%s valid lane%0d", nm, k), 32'(o_Valid[k]), 32'd0);
      if (use_rst) check($sformatf("%s result lane%0d", nm, k), o_Result[k], 32'd0);
    end
    repeat (40) begin
      @(negedge clk);
      if (o_Valid != 2'b00) pulses++;
    end
    check($sformatf("%s stray valid", nm), 32'(pulses), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset o_Ready lane%0d", k), 32'(o_Ready[k]), 32'd1);
      check($sformatf("reset o_Valid lane%0d", k), 32'(o_Valid[k]), 32'd0);
      check($sformatf("reset o_Result lane%0d", k), o_Result[k], 32'd0);
    end
    chk_en = 1'b1;
    rst = 1'b0;

    run_op("MUL 7*-3",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
    run_op("MULHU max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 0);
    run_op("REM -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 0);
    run_op("DIVU 100/7",    3'd5, 32'd100,      32'd7,        32'd14,        1'b0, 0);
    run_op("REMU 100/7",    3'd7, 32'd100,      32'd7,        32'd2,         1'b0, 0);
    run_op("DIV 5/0",       3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1, 0);
    run_op("REM 5/0",       3'd6, 32'd5,        32'd0,        32'd5,         1'b1, 0);
    run_op("DIV ovf",       3'd4, MIN_NEG,      32'hFFFF_FFFF, MIN_NEG,      1'b1, 0);
    run_op("REM ovf",       3'd6, MIN_NEG,      32'hFFFF_FFFF, 32'd0,        1'b1, 0);
    run_op("MULHSU -1*2",   3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0, 0);
    run_op("MULH min*min",  3'd1, MIN_NEG,      MIN_NEG,      32'h4000_0000, 1'b0, 0);
    run_op("DIVU backpres", 3'd5, 32'd1000,     32'd9,        32'd111,       1'b0, 5);

    abort_test("flush calc10", 10, 1'b0);
    abort_test("flush calc5",  5,  1'b0);
    abort_test("rst calc10",   10, 1'b1);

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      i_Valid       = ($urandom_range(0, 2) == 0);
      i_Funct3_3    = 3'($urandom_range(0, 7));
      i_Operand1    = pick();
      i_Operand2    = pick();
      i_ResultReady = ($urandom_range(0, 2) != 0);
      i_Flush       = ($urandom_range(0, 63) == 0);
      rst           = ($urandom_range(0, 511) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
